// File: rtl/invsqrt_arbiter_if.sv
// Requester-side bus of the shared inverse-square-root arbiter: operand
// requests in, one-hot grants out, and per-requester result pulses.
interface invsqrt_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    res_valid;
  logic [31:0]         res_data;
  logic                res_err;
  logic [ID_W-1:0]     res_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, res_valid, res_data, res_err, res_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, res_valid, res_data, res_err, res_id
  );
endinterface

// File: rtl/invsqrt_arbiter.sv
// Round-robin sharing of one pipelined InvertSQRoot core between N_REQ
// requesters; a tag pipeline routes each result back to its issuer.
module invsqrt_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  invsqrt_arbiter_if.slave                 bus,
  output logic [31:0]                      core_data_in,
  input  logic [31:0]                      core_data_out,
  output logic [$clog2(LATENCY+2)-1:0]     inflight
);

  localparam int unsigned CW    = ID_W + 1;
  localparam int unsigned INF_W = $clog2(LATENCY + 2);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_hit;
  logic [CW-1:0]   cand;
  logic [31:0]     gnt_data;
  logic            gnt_err;
  logic            xfer;
  logic            retire;
  tag_t            tag [1:LATENCY];

  // Round-robin search: walk offsets downward so the nearest valid from ptr wins.
  always_comb begin
    gnt_id  = '0;
    gnt_hit = 1'b0;
    cand    = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_id  = cand[ID_W-1:0];
        gnt_hit = 1'b1;
      end
    end
  end

  // Operand mux and illegal-operand classification for the granted requester.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_id == ID_W'(i)) gnt_data = bus.req_data[32*i +: 32];
    end
    gnt_err = gnt_data[31] || (gnt_data[30:23] == 8'h00) || (gnt_data[30:23] == 8'hFF);
  end

  always_comb begin
    bus.req_ready = '0;
    xfer          = en && !rst && gnt_hit;
    if (xfer) bus.req_ready = N_REQ'(1) << gnt_id;
    retire        = tag[LATENCY].v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      core_data_in  <= '0;
      bus.res_valid <= '0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.res_id    <= '0;
      inflight      <= '0;
      for (int k = 1; k <= int'(LATENCY); k++) tag[k] <= '0;
    end else begin
      if (xfer) begin
        ptr          <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        core_data_in <= gnt_data;
      end
      tag[1] <= xfer ? {1'b1, gnt_id, gnt_err} : '0;
      for (int k = 1; k < int'(LATENCY); k++) tag[k+1] <= tag[k];

      // Illegal operands get a quiet NaN instead of whatever the core produced.
      if (retire) begin
        bus.res_valid <= N_REQ'(1) << tag[LATENCY].id;
        bus.res_id    <= tag[LATENCY].id;
        bus.res_err   <= tag[LATENCY].err;
        bus.res_data  <= tag[LATENCY].err ? QNAN : core_data_out;
      end else begin
        bus.res_valid <= '0;
      end

      case ({xfer, retire})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Bench for invsqrt_arbiter: a stub core echoes operands after the pipeline
// delay, and a queue-based model predicts grants and routed results.
module tb_invsqrt_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] core_data_in;
  logic [31:0] core_data_out;
  logic [31:0] stub_q;
  logic [1:0]  inflight;

  always #5 clk = ~clk;

  invsqrt_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  invsqrt_arbiter #(.N_REQ(N), .LATENCY(LAT), .ID_W(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bus           (bus.slave),
    .core_data_in  (core_data_in),
    .core_data_out (core_data_out),
    .inflight      (inflight)
  );

  // The arbiter's own core_data_in register is the first delay stage.
  always @(posedge clk) stub_q <= core_data_in;
  assign core_data_out = stub_q;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          m_ptr, m_cyc, m_infl;
  logic [31:0] mdata [N];
  logic [31:0] m_cdi;
  logic [N-1:0] g_rdy, e_rdy, e_rv;
  logic [31:0] e_rd;
  logic        e_re;
  logic [IDW-1:0] e_rid;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit illegal(input logic [31:0] f);
    return f[31] || (f[30:23] == 8'h00) || (f[30:23] == 8'hFF);
  endfunction

  // One clock of stimulus plus reference-model update; no checking here.
  task automatic run_cycle(input logic [N-1:0] vld, input bit en_i, input bit rst_i);
    int   g;
    exp_t t;
    @(negedge clk);
    rst = rst_i;
    en  = en_i;
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = mdata[i];
    #1;
    g_rdy = bus.req_ready;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    e_rdy = (en_i && !rst_i && g >= 0) ? (N'(1) << g) : '0;
    if (e_rdy != '0) begin
      t.id = g; t.data = mdata[g]; t.err = illegal(mdata[g]); t.due = m_cyc + 1 + LAT;
      q.push_back(t);
      m_ptr = (g + 1) % N;
      m_infl++;
      m_cdi = mdata[g];
    end
    @(posedge clk);
    m_cyc++;
    if (rst_i) begin
      q.delete();
      m_ptr = 0; m_infl = 0; m_cdi = '0;
      e_rv = '0; e_rd = '0; e_re = 1'b0; e_rid = '0;
    end else if (q.size() > 0 && q[0].due == m_cyc) begin
      t = q.pop_front();
      e_rv  = N'(1) << t.id;
      e_rid = IDW'(t.id);
      e_re  = t.err;
      e_rd  = t.err ? 32'h7FC0_0000 : t.data;
      m_infl--;
    end else begin
      e_rv = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    run_cycle(4'hF, 1'b1, 1'b1);
    run_cycle(4'hF, 1'b1, 1'b1);
    n_cmp++; if (g_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset.req_ready got %b want 0000", g_rdy); end
    n_cmp++; if (bus.res_valid !== 4'b0000) begin n_bad++; $display("FAIL reset.res_valid got %b want 0000", bus.res_valid); end
    n_cmp++; if (bus.res_data !== 32'h0 || bus.res_err !== 1'b0 || bus.res_id !== 2'd0)
      begin n_bad++; $display("FAIL reset.res got data %h err %b id %0d want 0/0/0", bus.res_data, bus.res_err, bus.res_id); end
    n_cmp++; if (core_data_in !== 32'h0 || inflight !== 2'd0)
      begin n_bad++; $display("FAIL reset.core got cdi %h inflight %0d want 0/0", core_data_in, inflight); end
  endtask

  task automatic test_single();
    logic [1:0] want_infl [3];
    want_infl = '{2'd1, 2'd1, 2'd0};
    run_cycle(4'h0, 1'b1, 1'b1);
    mdata[1] = 32'h3F80_0000;
    run_cycle(4'b0010, 1'b1, 1'b0);
    n_cmp++; if (g_rdy !== 4'b0010) begin n_bad++; $display("FAIL single.req_ready got %b want 0010", g_rdy); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) run_cycle(4'h0, 1'b1, 1'b0);
      n_cmp++; if (inflight !== want_infl[i]) begin n_bad++; $display("FAIL single.inflight[%0d] got %0d want %0d", i, inflight, want_infl[i]); end
      n_cmp++; if (bus.res_valid !== e_rv) begin n_bad++; $display("FAIL single.res_valid[%0d] got %b want %b", i, bus.res_valid, e_rv); end
    end
    n_cmp++; if (bus.res_valid !== 4'b0010 || bus.res_id !== 2'd1 || bus.res_data !== 32'h3F80_0000 || bus.res_err !== 1'b0)
      begin n_bad++; $display("FAIL single.result got v %b id %0d data %h err %b want 0010/1/3f800000/0",
                              bus.res_valid, bus.res_id, bus.res_data, bus.res_err); end
    run_cycle(4'h0, 1'b1, 1'b0);
    n_cmp++; if (bus.res_valid !== 4'b0000) begin n_bad++; $display("FAIL single.pulse_end got %b want 0000", bus.res_valid); end
  endtask

  task automatic test_rotate();
    run_cycle(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) mdata[i] = 32'h3F00_0000 + 32'(i);
    for (int c = 0; c < 12; c++) begin
      run_cycle(4'hF, 1'b1, 1'b0);
      n_cmp++; if (g_rdy !== (N'(1) << (c % N))) begin n_bad++; $display("FAIL rotate.grant[%0d] got %b want %b", c, g_rdy, N'(1) << (c % N)); end
      n_cmp++; if (bus.res_valid !== e_rv || bus.res_id !== e_rid || bus.res_data !== e_rd)
        begin n_bad++; $display("FAIL rotate.result[%0d] got %b/%0d/%h want %b/%0d/%h", c, bus.res_valid, bus.res_id, bus.res_data, e_rv, e_rid, e_rd); end
      if (c >= 1) begin
        n_cmp++; if (inflight !== 2'd2) begin n_bad++; $display("FAIL rotate.inflight[%0d] got %0d want 2", c, inflight); end
      end
    end
  endtask

  task automatic test_illegal();
    run_cycle(4'h0, 1'b1, 1'b1);
    mdata[0] = 32'hBF80_0000; mdata[1] = 32'h0000_0000; mdata[2] = 32'h7F80_0000;
    for (int c = 0; c < 6; c++) begin
      run_cycle((c < 3) ? (N'(1) << c) : 4'h0, 1'b1, 1'b0);
      n_cmp++; if (bus.res_valid !== e_rv || bus.res_err !== e_re || bus.res_data !== e_rd)
        begin n_bad++; $display("FAIL illegal[%0d] got %b/%b/%h want %b/%b/%h", c, bus.res_valid, bus.res_err, bus.res_data, e_rv, e_re, e_rd); end
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (bus.res_err !== 1'b1 || bus.res_data !== 32'h7FC0_0000)
          begin n_bad++; $display("FAIL illegal.nan[%0d] got err %b data %h want 1/7fc00000", c, bus.res_err, bus.res_data); end
      end
    end
  endtask

  task automatic test_en_low();
    run_cycle(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) mdata[i] = 32'h4000_0000 + 32'(i << 8);
    run_cycle(4'hF, 1'b1, 1'b0);
    run_cycle(4'hF, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      run_cycle(4'hF, 1'b0, 1'b0);
      n_cmp++; if (g_rdy !== 4'b0000) begin n_bad++; $display("FAIL en_low.req_ready[%0d] got %b want 0000", c, g_rdy); end
      n_cmp++; if (bus.res_valid !== e_rv || bus.res_data !== e_rd || inflight !== 2'(m_infl))
        begin n_bad++; $display("FAIL en_low.drain[%0d] got %b/%h/%0d want %b/%h/%0d", c, bus.res_valid, bus.res_data, inflight, e_rv, e_rd, m_infl); end
    end
    n_cmp++; if (inflight !== 2'd0) begin n_bad++; $display("FAIL en_low.final_inflight got %0d want 0", inflight); end
  endtask

  task automatic test_reset_mid();
    run_cycle(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) mdata[i] = 32'h3E00_0000 + 32'(i);
    run_cycle(4'hF, 1'b1, 1'b0);
    run_cycle(4'hF, 1'b1, 1'b0);
    run_cycle(4'hF, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      run_cycle(4'h0, 1'b1, 1'b0);
      n_cmp++; if (bus.res_valid !== 4'b0000 || bus.res_data !== 32'h0 || bus.res_id !== 2'd0 || inflight !== 2'd0 || core_data_in !== 32'h0)
        begin n_bad++; $display("FAIL reset_mid.quiet[%0d] got v %b data %h id %0d infl %0d cdi %h want all 0",
                                c, bus.res_valid, bus.res_data, bus.res_id, inflight, core_data_in); end
    end
    run_cycle(4'hF, 1'b1, 1'b0);
    n_cmp++; if (g_rdy !== 4'b0001) begin n_bad++; $display("FAIL reset_mid.first_grant got %b want 0001", g_rdy); end
  endtask

  task automatic test_pair();
    logic [N-1:0] want [4];
    want = '{4'b1000, 4'b0100, 4'b1000, 4'b0100};
    run_cycle(4'h0, 1'b1, 1'b1);
    mdata[2] = 32'h4080_0000; mdata[3] = 32'h4100_0000;
    run_cycle(4'b0100, 1'b1, 1'b0);
    n_cmp++; if (g_rdy !== 4'b0100) begin n_bad++; $display("FAIL pair.first got %b want 0100", g_rdy); end
    for (int c = 0; c < 4; c++) begin
      run_cycle(4'b1100, 1'b1, 1'b0);
      n_cmp++; if (g_rdy !== want[c]) begin n_bad++; $display("FAIL pair.grant[%0d] got %b want %b", c, g_rdy, want[c]); end
      n_cmp++; if (bus.res_valid !== e_rv || bus.res_id !== e_rid)
        begin n_bad++; $display("FAIL pair.result[%0d] got %b/%0d want %b/%0d", c, bus.res_valid, bus.res_id, e_rv, e_rid); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] vld;
    bit en_r, rst_r;
    run_cycle(4'h0, 1'b1, 1'b1);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       mdata[i] = {1'b1, 31'($urandom)};
          1:       mdata[i] = {1'b0, 8'h00, 23'($urandom)};
          2:       mdata[i] = {1'b0, 8'hFF, 23'($urandom)};
          default: mdata[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
      end
      vld   = N'($urandom);
      en_r  = ($urandom_range(0, 9) != 0);
      rst_r = ($urandom_range(0, 49) == 0);
      run_cycle(vld, en_r, rst_r);
      n_cmp++; if (g_rdy !== e_rdy) begin n_bad++; $display("FAIL random.req_ready[%0d] got %b want %b", c, g_rdy, e_rdy); end
      n_cmp++; if (bus.res_valid !== e_rv || bus.res_id !== e_rid || bus.res_err !== e_re || bus.res_data !== e_rd)
        begin n_bad++; $display("FAIL random.result[%0d] got %b/%0d/%b/%h want %b/%0d/%b/%h", c,
                                bus.res_valid, bus.res_id, bus.res_err, bus.res_data, e_rv, e_rid, e_re, e_rd); end
      n_cmp++; if (inflight !== 2'(m_infl) || core_data_in !== m_cdi)
        begin n_bad++; $display("FAIL random.state[%0d] got infl %0d cdi %h want %0d/%h", c, inflight, core_data_in, m_infl, m_cdi); end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    m_ptr = 0; m_cyc = 0; m_infl = 0; m_cdi = '0;
    for (int i = 0; i < N; i++) mdata[i] = 32'h3F80_0000;
    test_reset();
    test_single();
    test_rotate();
    test_illegal();
    test_en_low();
    test_reset_mid();
    test_pair();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/invsqrt_arbiter.md
Name: invsqrt_arbiter

Overview:
- Shares one fully pipelined InvertSQRoot core between N_REQ requesters.
- Each cycle, a round-robin arbiter grants at most one requester and drives its operand onto the core's DataIn.
- A tag shift register tracks each in-flight operation's requester ID and error flag in step with the core's fixed latency.
- Each result is routed back as a one-cycle pulse to the requester that issued it. The block sits between the requester clients and the single InvertSQRoot instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 2, InvertSQRoot cycles from a DataIn change to a valid DataOut (≥1).
- ID_W, 2, width of requester ID; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  grant enable; when low, no new grants, and the pipeline keeps draining.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  32*N_REQ  IEEE-754 single operands; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant (combinational); at most one bit high.
- core_data_in  out  32  registered operand to InvertSQRoot DataIn.
- core_data_out  in  32  InvertSQRoot DataOut.
- res_valid  out  N_REQ  one-hot, one-cycle result pulse to the owning requester.
- res_data  out  32  result value, valid while any res_valid bit is high.
- res_err  out  1  result substituted because the operand was illegal.
- res_id  out  ID_W  requester ID of the current result.
- inflight  out  clog2(LATENCY+2)  number of valid tags in the pipeline.

Behaviour:

Reset:
- On rst at a clock edge, all registered outputs are 0: core_data_in, res_valid, res_data, res_err, res_id, inflight.
- Also cleared: all tag stages, and the RR pointer is set to 0.
- req_ready is forced to 0 while rst is high.
- Reset mid-operation discards in-flight results; no res_valid follows for them.

Arbitration:
- Grant g is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo N_REQ.
- req_ready[g]=1 only when en=1 and rst=0.
- A transfer occurs on the edge where req_valid[g]&req_ready[g]=1.
- On a transfer, ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- A requester that keeps valid high while ungranted must hold req_data stable. The block does not latch ungranted data.

Issue:
- On a transfer edge, core_data_in <= req_data[g] and tag[1] <= {v=1, id=g, err}.
- With no transfer, core_data_in holds its previous value and tag[1] <= {v=0}.
- err=1 if the operand's sign bit is 1, its exponent is 0x00 (zero or denormal), or its exponent is 0xFF (Inf/NaN).
- Every edge, tag[k+1] <= tag[k] for k=1..LATENCY-1.

Retire:
- At each edge, if tag[LATENCY].v=1:
  - res_valid <= onehot(tag.id) and res_id <= tag.id.
  - If tag.err=1, res_data <= 0x7FC00000 and res_err <= 1.
  - Otherwise res_data <= core_data_out and res_err <= 0.
- If tag[LATENCY].v=0, res_valid <= 0, and res_data, res_id and res_err hold.
- Latency: res_valid is high in the cycle following edge E0+LATENCY, where E0 is the accept edge. That is LATENCY+1 cycles after acceptance.
- Throughput is 1 operation per cycle. There is no backpressure on results; requesters must accept the pulse.

inflight:
- +1 on issue, −1 on retire; unchanged when both or neither happen.
- Never exceeds LATENCY.

Simultaneous events and ordering:
- Issue and retire in the same cycle are independent.
- en falling with operations in flight: they still retire normally.
- Results retire in issue order.

Test Plan:
Benches use a stub core that delays core_data_in by LATENCY registers, so an expected res_data equals the issued operand.
1. Single request: req_valid[1]=1, data 0x3F800000 at accept edge E0 -> res_valid=4'b0010, res_id=1, res_data=0x3F800000, res_err=0 in the cycle after edge E0+2; inflight goes 1,1,0.
2. All four valid continuously, data 0x3F000000+i -> grants rotate 0,1,2,3,0…; results arrive on consecutive cycles in the same order with matching IDs; inflight stays at 2.
3. Illegal operands: 0xBF800000, 0x00000000, 0x7F800000 -> each returns res_err=1 and res_data=0x7FC00000.
4. en=0 while req_valid=4'b1111 -> req_ready=0 and no new issue; earlier in-flight results still retire; inflight drains to 0.
5. rst pulsed one cycle after two accepts -> no res_valid afterwards; all outputs 0; next grant goes to requester 0.
6. Requesters 2 and 3 only, ptr=3 after a grant to 2 -> next grant is 3, then wraps to 2, skipping idle requesters 0 and 1.
